// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Holds the source-select encoding, the zero-register constant and default widths.
// No logic; imported by the arbiter and its load-result FIFO.
package wb_pkg;

  localparam int DW_DEF       = 32;
  localparam int AW_DEF       = 5;
  localparam int LD_DEPTH_DEF = 4;

  // Register 0 is hardwired: results targeting it are consumed but never written.
  localparam int REG_ZERO = 0;

  // Which producer owns the write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LD   = 2'd2,
    SRC_MD   = 2'd3
  } src_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering load results ahead of the write-port arbiter.
// Latency: a push is visible at head after the next edge; head is combinational from storage.
// Backpressure: full is asserted from the current state; pushes while full and pops while empty are ignored.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = LD_DEPTH_DEF,
  parameter int W     = AW_DEF + DW_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int IW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IW:0]  wr_ptr;
  logic [IW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign head  = mem[rd_ptr[IW-1:0]];

  // Advance pointers; reset empties the queue and discards any stored entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[IW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU, load and mult/div results onto the register-file write port and tracks pending destinations.
// Latency: a granted result appears on A3/WD/WE after the next edge; loads spend one extra cycle in the FIFO.
// Backpressure: ALU is never stalled; loads see ld_ready=!full; mult/div sees md_ready only on its grant.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int LD_DEPTH = LD_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_rd,
  input  logic [DW-1:0] ld_data,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [AW-1:0] md_rd,
  input  logic [DW-1:0] md_data,
  input  logic [AW-1:0] q1,
  input  logic [AW-1:0] q2,
  output logic          busy1,
  output logic          busy2,
  output logic [AW-1:0] A3,
  output logic [DW-1:0] WD,
  output logic          WE
);

  localparam int NREG = 1 << AW;
  localparam int FW   = AW + DW;

  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_head;
  logic [AW-1:0] head_rd;
  logic [DW-1:0] head_data;
  logic          ld_push;
  logic          ld_pop;

  src_t          grant;
  src_t          rr_pref;
  logic [AW-1:0] g_rd;
  logic [DW-1:0] g_data;
  logic          g_write;

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;

  // Ready comes from the pre-pop state, so a full FIFO refuses a push even while popping.
  assign ld_ready = !fifo_full;
  assign ld_push  = ld_valid && ld_ready;

  wb_fifo #(
    .DEPTH (LD_DEPTH),
    .W     (FW)
  ) u_ld_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ld_push),
    .din   ({ld_rd, ld_data}),
    .pop   (ld_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign {head_rd, head_data} = fifo_head;

  // Pick this cycle's owner: ALU absolutely, otherwise round-robin between FIFO head and mult/div.
  always_comb begin
    grant = SRC_NONE;
    if (reset) begin
      if (alu_valid) begin
        grant = SRC_ALU;
      end else if (!fifo_empty && (!md_valid || rr_pref == SRC_LD)) begin
        grant = SRC_LD;
      end else if (md_valid) begin
        grant = SRC_MD;
      end
    end
  end

  // Route the winner's destination and data toward the output registers.
  always_comb begin
    g_rd   = '0;
    g_data = '0;
    case (grant)
      SRC_ALU: begin
        g_rd   = alu_rd;
        g_data = alu_data;
      end
      SRC_LD: begin
        g_rd   = head_rd;
        g_data = head_data;
      end
      SRC_MD: begin
        g_rd   = md_rd;
        g_data = md_data;
      end
      default: begin
        g_rd   = '0;
        g_data = '0;
      end
    endcase
  end

  assign md_ready = (grant == SRC_MD);
  assign ld_pop   = (grant == SRC_LD);
  // Results aimed at register 0 complete their handshake but produce no write.
  assign g_write  = (grant != SRC_NONE) && (g_rd != AW'(REG_ZERO));

  // Register the write port; without a real write, address and data hold their last value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      WE <= 1'b0;
      A3 <= '0;
      WD <= '0;
    end else begin
      WE <= g_write;
      if (g_write) begin
        A3 <= g_rd;
        WD <= g_data;
      end
    end
  end

  // Hand preference to the other shared source after every load or mult/div grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_pref <= SRC_LD;
    end else if (grant == SRC_LD) begin
      rr_pref <= SRC_MD;
    end else if (grant == SRC_MD) begin
      rr_pref <= SRC_LD;
    end
  end

  // Next scoreboard: clear the retiring destination, then set the newly issued one so a new issue wins.
  always_comb begin
    pend_nxt = pend;
    if (g_write) begin
      pend_nxt[g_rd] = 1'b0;
    end
    if (issue_valid && issue_rd != AW'(REG_ZERO)) begin
      pend_nxt[issue_rd] = 1'b1;
    end
    pend_nxt[REG_ZERO] = 1'b0;
  end

  // Hold the pending-destination scoreboard.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  // Decode queries see only registered state; same-cycle issue or retire is not bypassed.
  assign busy1 = pend[q1];
  assign busy2 = pend[q2];

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LD_DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_data;
  logic          md_valid;
  logic          md_ready;
  logic [AW-1:0] md_rd;
  logic [DW-1:0] md_data;
  logic [AW-1:0] q1;
  logic [AW-1:0] q2;
  logic          busy1;
  logic          busy2;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD;
  logic          WE;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of buffered loads, array of outstanding registers,
  // last committed write, and which shared source is preferred next.
  bit [AW+DW-1:0] m_q[$];
  bit             m_pend[32];
  bit             m_we;
  bit [AW-1:0]    m_a3;
  bit [DW-1:0]    m_wd;
  bit             m_pref_md;

  wb_arbiter #(.DW(DW), .AW(AW), .LD_DEPTH(LD_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .q1(q1), .q2(q2), .busy1(busy1), .busy2(busy2),
    .A3(A3), .WD(WD), .WE(WE)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic bit exp_ld_ready();
    return m_q.size() < LD_DEPTH;
  endfunction

  function automatic bit exp_md_ready();
    return reset && !alu_valid && md_valid && (m_q.size() == 0 || m_pref_md);
  endfunction

  task automatic model_step();
    bit          acc;
    bit          g;
    bit [AW-1:0] r;
    bit [DW-1:0] d;
    if (!reset) begin
      m_q.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_we = 1'b0;
      m_a3 = '0;
      m_wd = '0;
      m_pref_md = 1'b0;
      return;
    end
    acc = ld_valid && (m_q.size() < LD_DEPTH);
    g = 1'b0;
    r = '0;
    d = '0;
    if (alu_valid) begin
      g = 1'b1; r = alu_rd; d = alu_data;
    end else if (m_q.size() > 0 && !(md_valid && m_pref_md)) begin
      {r, d} = m_q.pop_front();
      g = 1'b1;
      m_pref_md = 1'b1;
    end else if (md_valid) begin
      g = 1'b1; r = md_rd; d = md_data;
      m_pref_md = 1'b0;
    end
    if (g && r != 0) begin
      m_we = 1'b1; m_a3 = r; m_wd = d;
      m_pend[r] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    if (acc) m_q.push_back({ld_rd, ld_data});
  endtask

  // Advance one clock: model follows the edge, then return at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h5555_AAAA;
    ld_valid = 1'b1; ld_rd = 5'd3; issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    tick();
    reset = 1'b1;
    idle();
    q1 = 5'd4; q2 = 5'd7;
    #1;
    checks++; if (WE !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", WE); end
    checks++; if (A3 !== 5'd0) begin failures++; $display("FAIL reset_a3: got %0d want 0", A3); end
    checks++; if (WD !== 32'd0) begin failures++; $display("FAIL reset_wd: got %h want 0", WD); end
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
    checks++; if (md_ready !== 1'b0) begin failures++; $display("FAIL reset_md_ready: got %b want 0", md_ready); end
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b%b want 00", busy1, busy2); end
    tick();
  endtask

  task automatic test_alu_write();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    tick();
    idle();
    #1;
    checks++; if (WE !== 1'b1 || A3 !== 5'd5 || WD !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL alu_write: got WE=%b A3=%0d WD=%h want 1/5/deadbeef", WE, A3, WD);
    end
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
    tick();
    idle();
    q1 = 5'd0;
    #1;
    checks++; if (WE !== 1'b0 || A3 !== 5'd5 || WD !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL alu_rd0_hold: got WE=%b A3=%0d WD=%h want 0/5/deadbeef", WE, A3, WD);
    end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL alu_rd0_busy: got %b want 0", busy1); end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd8;
    tick();
    idle();
    q1 = 5'd8;
    #1;
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL sb_set: busy1 got %b want 1", busy1); end
    ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'hCAFE_0008;
    tick();
    idle();
    #1;
    checks++; if (busy1 !== 1'b1 || WE !== 1'b0) begin
      failures++; $display("FAIL sb_enqueue: got busy1=%b WE=%b want 1/0", busy1, WE);
    end
    tick();
    #1;
    checks++; if (WE !== 1'b1 || A3 !== 5'd8 || WD !== 32'hCAFE_0008) begin
      failures++; $display("FAIL sb_load_write: got WE=%b A3=%0d WD=%h want 1/8/cafe0008", WE, A3, WD);
    end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL sb_clear: busy1 got %b want 0", busy1); end
    issue_valid = 1'b1; issue_rd = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
    tick();
    idle();
    q1 = 5'd9; q2 = 5'd0;
    #1;
    checks++; if (busy1 !== 1'b1 || busy2 !== 1'b0) begin
      failures++; $display("FAIL sb_set_wins: got busy1=%b busy2=%b want 1/0", busy1, busy2);
    end
    checks++; if (WE !== 1'b1 || A3 !== 5'd9) begin
      failures++; $display("FAIL sb_same_cycle_write: got WE=%b A3=%0d want 1/9", WE, A3);
    end
  endtask

  task automatic test_fifo_full();
    int      acc;
    bit      fire;
    int      got[$];
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'(i);
      ld_valid = (acc < 5); ld_rd = 5'(20 + acc); ld_data = 32'(100 + acc);
      #1;
      fire = ld_valid && ld_ready;
      tick();
      if (fire) acc++;
    end
    idle();
    #1;
    checks++; if (acc != 4 || ld_ready !== 1'b0) begin
      failures++; $display("FAIL fifo_full: accepted=%0d ld_ready=%b want 4/0", acc, ld_ready);
    end
    for (int j = 0; j < 8; j++) begin
      ld_valid = (acc < 5); ld_rd = 5'(20 + acc); ld_data = 32'(100 + acc);
      #1;
      fire = ld_valid && ld_ready;
      tick();
      if (fire) acc++;
      #1;
      if (WE === 1'b1) got.push_back(int'(A3));
    end
    idle();
    checks++; if (got.size() != 5) begin
      failures++; $display("FAIL fifo_drain_count: got %0d writes want 5", got.size());
    end
    for (int k = 0; k < got.size() && k < 5; k++) begin
      checks++; if (got[k] != 20 + k) begin
        failures++; $display("FAIL fifo_drain_order[%0d]: got A3=%0d want %0d", k, got[k], 20 + k);
      end
    end
  endtask

  task automatic test_round_robin();
    int  mdcnt;
    bit  fire;
    int  exp_a3[6];
    exp_a3 = '{1, 16, 2, 17, 3, 18};
    reset = 1'b0;
    idle();
    tick();
    reset = 1'b1;
    tick();
    mdcnt = 0;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd30; alu_data = 32'(i);
      ld_valid = 1'b1; ld_rd = 5'(1 + i); ld_data = 32'(200 + i);
      md_valid = 1'b1; md_rd = 5'd16; md_data = 32'h0000_0016;
      #1;
      checks++; if (md_ready !== 1'b0) begin failures++; $display("FAIL rr_alu_priority: md_ready got %b want 0", md_ready); end
      tick();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      md_valid = 1'b1; md_rd = 5'(16 + mdcnt); md_data = 32'(300 + mdcnt);
      #1;
      checks++; if (md_ready !== 1'(k % 2)) begin
        failures++; $display("FAIL rr_md_ready[%0d]: got %b want %0d", k, md_ready, k % 2);
      end
      fire = md_valid && md_ready;
      tick();
      if (fire) mdcnt++;
      #1;
      checks++; if (WE !== 1'b1 || A3 !== 5'(exp_a3[k])) begin
        failures++; $display("FAIL rr_order[%0d]: got WE=%b A3=%0d want 1/%0d", k, WE, A3, exp_a3[k]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_rd = 5'd8;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'(i);
      ld_valid = 1'b1; ld_rd = 5'(12 + i); ld_data = 32'(400 + i);
      tick();
    end
    idle();
    tick();
    reset = 1'b0;
    tick();
    q1 = 5'd8;
    #1;
    checks++; if (WE !== 1'b0 || ld_ready !== 1'b1 || busy1 !== 1'b0) begin
      failures++; $display("FAIL reset_mid: got WE=%b ld_ready=%b busy1=%b want 0/1/0", WE, ld_ready, busy1);
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      checks++; if (WE !== 1'b0) begin
        failures++; $display("FAIL reset_mid_stale[%0d]: WE got %b want 0 (A3=%0d)", i, WE, A3);
      end
    end
  endtask

  task automatic test_random();
    bit ld_fire;
    bit md_fire;
    ld_fire = 1'b0;
    md_fire = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(99) != 0);
      issue_valid = 1'($urandom_range(1)); issue_rd = 5'($urandom_range(31));
      alu_valid = ($urandom_range(3) == 0); alu_rd = 5'($urandom_range(31)); alu_data = $urandom;
      if (!ld_valid || ld_fire) begin
        ld_valid = 1'($urandom_range(1)); ld_rd = 5'($urandom_range(31)); ld_data = $urandom;
      end
      if (!md_valid || md_fire) begin
        md_valid = 1'($urandom_range(1)); md_rd = 5'($urandom_range(31)); md_data = $urandom;
      end
      q1 = 5'($urandom_range(31)); q2 = 5'($urandom_range(31));
      #1;
      checks++; if (WE !== m_we || (m_we && (A3 !== m_a3 || WD !== m_wd))) begin
        failures++; $display("FAIL rand_write[%0d]: got WE=%b A3=%0d WD=%h want %b/%0d/%h", n, WE, A3, WD, m_we, m_a3, m_wd);
      end
      checks++; if (A3 !== m_a3 || WD !== m_wd) begin
        failures++; $display("FAIL rand_hold[%0d]: got A3=%0d WD=%h want %0d/%h", n, A3, WD, m_a3, m_wd);
      end
      checks++; if (ld_ready !== exp_ld_ready()) begin
        failures++; $display("FAIL rand_ld_ready[%0d]: got %b want %b", n, ld_ready, exp_ld_ready());
      end
      checks++; if (md_ready !== exp_md_ready()) begin
        failures++; $display("FAIL rand_md_ready[%0d]: got %b want %b", n, md_ready, exp_md_ready());
      end
      checks++; if (busy1 !== m_pend[q1] || busy2 !== m_pend[q2]) begin
        failures++; $display("FAIL rand_busy[%0d]: q1=%0d q2=%0d got %b%b want %b%b", n, q1, q2, busy1, busy2, m_pend[q1], m_pend[q2]);
      end
      ld_fire = ld_valid && ld_ready;
      md_fire = md_valid && md_ready;
      tick();
    end
    reset = 1'b1;
    idle();
  endtask

  initial begin
    reset = 1'b0;
    q1 = '0; q2 = '0;
    idle();
    m_q.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_we = 1'b0; m_a3 = '0; m_wd = '0; m_pref_md = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu_write();
    test_scoreboard();
    test_fifo_full();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

- Write-port initiator for the 32-word × 32-bit register file.
- Merges three result sources into the file's single write port (A3/WD/WE):
  - single-cycle ALU results;
  - variable-latency load results;
  - multi-cycle multiply/divide results.
- Keeps a pending-destination scoreboard so the decode stage can stall on registers that have outstanding writes.
- Sits between the execute/memory stages and the register file write port.

## Interface
- DW, 32, data width
- AW, 5, register address width (2^AW registers)
- LD_DEPTH, 4, load-result FIFO depth (power of 2, ≥2)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- issue_valid  in  1  instruction with destination issued this cycle
- issue_rd  in  AW  destination register of issued instruction
- alu_valid  in  1  ALU result present (no backpressure)
- alu_rd  in  AW  ALU destination
- alu_data  in  DW  ALU result
- ld_valid / ld_ready  in / out  1  load-result handshake
- ld_rd  in  AW  load destination
- ld_data  in  DW  load data
- md_valid / md_ready  in / out  1  mult/div-result handshake
- md_rd  in  AW  mult/div destination
- md_data  in  DW  mult/div result
- q1, q2  in  AW  decode source-register queries
- busy1, busy2  out  1  pending write on q1/q2 (combinational)
- A3  out  AW  register file write address (registered)
- WD  out  DW  register file write data (registered)
- WE  out  1  register file write enable (registered)

## Operation
- Reset (reset=0 at a clk edge) clears all state:
  - WE=0, A3=0, WD=0;
  - scoreboard pend=0, so busy1=busy2=0;
  - FIFO empty, so ld_ready=1;
  - md_ready=0;
  - round-robin pointer set to LD.
- Reset mid-operation discards FIFO contents and the pending grant.
- Load path: a transfer occurs when ld_valid & ld_ready. It pushes {ld_rd, ld_data} into the FIFO. ld_ready = !full.
- Arbitration, evaluated each cycle:
  - alu_valid=1: ALU wins, absolutely. ALU results are never stalled.
  - alu_valid=0: choose between the FIFO head (non-empty) and md_valid.
    - Only one candidate: it wins.
    - Both: round-robin. Pointer names the preferred source and flips to the other after each LD/MD grant.
  - md_ready = grant to MD. It is combinational from md_valid, alu_valid and FIFO state.
  - An LD grant pops the FIFO head.
- The granted source's {rd, data} is registered into A3/WD next edge.
  - WE=1 only if rd≠0.
  - rd=0 results are consumed (handshake completes) but write nothing: WE=0, A3/WD hold.
  - With no grant: WE=0, A3/WD hold.
- Scoreboard pend[2^AW-1:0]:
  - issue_valid & issue_rd≠0 sets pend[issue_rd].
  - A grant with rd≠0 clears pend[rd] on the same edge the write is registered.
  - Set and clear of the same index in one cycle: set wins (the newer instruction is outstanding).
  - pend[0] is always 0.
- busy1 = pend[q1]; busy2 = pend[q2]. Query of register 0 returns 0.
- FIFO push and pop in the same cycle when full is legal: ld_ready stays 0 that cycle (ready is computed from the pre-pop state), so no push occurs.

## Timing
- ALU result at edge t → WE/A3/WD valid after edge t+1, i.e. 1-cycle latency.
- Load accepted at edge t → earliest write after edge t+2: enqueue, then head grant.
- MD granted in cycle t → write after edge t+1.
- Register file captures on the edge following WE=1. Write-to-read visibility therefore depends on the file, not this block.
- busy1/busy2 reflect scoreboard state after the most recent edge; there is no bypass of same-cycle issue or clear.
- Sustained alu_valid starves LD/MD. The upstream issue logic guarantees gaps.

## Structure
- Shared package wb_pkg holds:
  - source-select encoding: SRC_NONE, SRC_ALU, SRC_LD, SRC_MD;
  - the zero-register constant REG_ZERO = 0;
  - DW/AW defaults.
- One sub-module, wb_fifo: synchronous FIFO, parameter LD_DEPTH, width AW+DW.
  - Ports: push, pop, full, empty, head.
  - Pointers are one bit wider than the index, for full/empty detection.
- The top level contains the arbiter, round-robin pointer, output registers and scoreboard.

## Test plan
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF → next cycle WE=1, A3=5, WD=0xDEADBEEF.
- alu_rd=0, alu_data=0x1234 → WE stays 0, A3/WD unchanged, no scoreboard change.
- issue_valid=1, issue_rd=8, then q1=8 → busy1=1. A load to rd=8 is accepted → busy1=0 on the same edge WE=1, A3=8.
- Same cycle: issue_rd=9 plus ALU grant to rd=9 → busy for q1=9 stays 1.
- alu_valid=1 held 6 cycles while 5 loads are offered → after 4 accepts ld_ready=0. Once ALU idles, loads drain in order, one per cycle.
- ALU idle with FIFO non-empty and md_valid held → grants alternate LD, MD, LD, MD, with md_ready=1 only on MD cycles.
- reset=0 asserted mid-drain with 3 FIFO entries and pend[8]=1 → next cycle WE=0, ld_ready=1, busy=0; no stale writes afterward.
